// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and constants for the key debounce block.
// The optional toggle output is selected with KEY_DEBOUNCE_TOGGLE_EN in the top module.
package key_debounce_pkg;

    // Default qualification length in CLK cycles
    localparam int CNT_MAX_DEFAULT = 4;

    // Filter FSM states; the encoding keeps bit 0 equal to the accepted level
    // in the stable states so a single-bit flip marks entry into a WAIT state.
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_PRESS   = 2'b01,
        PRESSED      = 2'b11,
        WAIT_RELEASE = 2'b10
    } state_t;

    // True while a candidate transition is being qualified
    function automatic logic is_wait_state(input state_t s);
        logic busy_v;
        case (s)
            WAIT_PRESS:   busy_v = 1'b1;
            WAIT_RELEASE: busy_v = 1'b1;
            default:      busy_v = 1'b0;
        endcase
        return busy_v;
    endfunction

endpackage

// File: rtl/key_debounce_sync_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit level.
// Synchronous active-high reset clears both stages. Only the second stage
// may be used by downstream logic.
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic level,
    output logic level_sync
);

    logic sync1_r;
    logic sync2_r;

    // Shift the raw level through two stages to settle metastability
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= level;
            sync2_r <= sync1_r;
        end
    end

    assign level_sync = sync2_r;

endmodule

// File: rtl/key_debounce_sync.sv
// key_debounce_sync: synchronises a bouncing key level, filters it with a
// stability-counter FSM and produces a clean level plus one-cycle rise/fall
// strobes. Defining KEY_DEBOUNCE_TOGGLE_EN adds TOGGLE_OUT, a level that
// flips on every accepted press.
module key_debounce_sync
    import key_debounce_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_IN,
    output logic KEY_OUT,
    output logic KEY_RISE,
    output logic KEY_FALL,
    output logic BUSY
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    ,
    output logic TOGGLE_OUT
`endif
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             key_sync_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             key_out_r;
    logic             key_rise_r;
    logic             key_fall_r;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    logic             toggle_r;
`else
    // No stored toggle level in this build
`endif

    sync_2ff u_sync (
        .CLK        (CLK),
        .RST        (RST),
        .level      (KEY_IN),
        .level_sync (key_sync_s)
    );

    // Debounce FSM, qualification counter and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            key_out_r  <= 1'b0;
            key_rise_r <= 1'b0;
            key_fall_r <= 1'b0;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
            toggle_r   <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a transition is accepted below
            key_rise_r <= 1'b0;
            key_fall_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r     <= CNT_ZERO;
                    key_out_r <= 1'b0;
                    if (key_sync_s) begin
                        state_r <= WAIT_PRESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_PRESS: begin
                    if (!key_sync_s) begin
                        // Bounce: drop the candidate silently
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r    <= PRESSED;
                        cnt_r      <= CNT_ZERO;
                        key_out_r  <= 1'b1;
                        key_rise_r <= 1'b1;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
                        toggle_r   <= ~toggle_r;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                PRESSED: begin
                    cnt_r     <= CNT_ZERO;
                    key_out_r <= 1'b1;
                    if (!key_sync_s) begin
                        state_r <= WAIT_RELEASE;
                    end else begin
                        state_r <= PRESSED;
                    end
                end
                WAIT_RELEASE: begin
                    if (key_sync_s) begin
                        // Bounce: return to the held level silently
                        state_r <= PRESSED;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r    <= IDLE;
                        cnt_r      <= CNT_ZERO;
                        key_out_r  <= 1'b0;
                        key_fall_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    // Corrupted state register: fall back to a safe idle
                    state_r    <= IDLE;
                    cnt_r      <= CNT_ZERO;
                    key_out_r  <= 1'b0;
                    key_rise_r <= 1'b0;
                    key_fall_r <= 1'b0;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
                    toggle_r   <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign KEY_OUT  = key_out_r;
    assign KEY_RISE = key_rise_r;
    assign KEY_FALL = key_fall_r;
    assign BUSY     = is_wait_state(state_r);
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    assign TOGGLE_OUT = toggle_r;
`endif

endmodule

// File: tb/tb_key_debounce_sync.sv
// tb_key_debounce_sync: scoreboard bench for key_debounce_sync with CNT_MAX=4.
// Expected {KEY_OUT,KEY_RISE,KEY_FALL,BUSY} per cycle are pushed when the
// stimulus is driven and popped after the clock edge for comparison.
module tb_key_debounce_sync;

    logic CLK;
    logic RST;
    logic KEY_IN;
    logic KEY_OUT;
    logic KEY_RISE;
    logic KEY_FALL;
    logic BUSY;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    logic TOGGLE_OUT;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    key_debounce_sync #(.CNT_MAX(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KEY_IN   (KEY_IN),
        .KEY_OUT  (KEY_OUT),
        .KEY_RISE (KEY_RISE),
        .KEY_FALL (KEY_FALL),
        .BUSY     (BUSY)
`ifdef KEY_DEBOUNCE_TOGGLE_EN
        ,
        .TOGGLE_OUT (TOGGLE_OUT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected outputs j edges after the edge that first samples a clean new level
    function automatic logic [3:0] exp_clean(input int j, input logic new_lvl);
        logic out_v, rise_v, fall_v, busy_v;
        out_v  = (j >= 6) ? new_lvl : ~new_lvl;
        rise_v = (j == 6) && new_lvl;
        fall_v = (j == 6) && !new_lvl;
        busy_v = (j >= 2) && (j <= 5);
        return {out_v, rise_v, fall_v, busy_v};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs, exp;
        RST = 1'b1;
        KEY_IN = 1'b0;
        for (int j = 0; j < 4; j++) begin
            RST = (j < 2) ? 1'b1 : 1'b0;
            exp_q.push_back(4'b0000);
            tick();
            obs = {KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset j=%0d got=%b want=%b", j, obs, exp);
            end
        end
    endtask

    task automatic test_press();
        logic [3:0] obs, exp;
        for (int j = 0; j < 8; j++) begin
            KEY_IN = 1'b1;
            exp_q.push_back(exp_clean(j, 1'b1));
            tick();
            obs = {KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL press j=%0d got=%b want=%b", j, obs, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] obs, exp;
        for (int j = 0; j < 8; j++) begin
            KEY_IN = 1'b0;
            exp_q.push_back(exp_clean(j, 1'b0));
            tick();
            obs = {KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL release j=%0d got=%b want=%b", j, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] obs, exp;
        logic [11:0] pat;
        logic [11:0] busy_tbl;
        pat      = 12'b0000_0001_1011;  // bit j: 1,1,0,1,1,0 then 0s
        busy_tbl = 12'b0000_0110_1100;  // busy after edges 2,3,5,6
        for (int j = 0; j < 12; j++) begin
            KEY_IN = pat[j];
            exp_q.push_back({3'b000, busy_tbl[j]});
            tick();
            obs = {KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bounce j=%0d got=%b want=%b", j, obs, exp);
            end
        end
    endtask

    task automatic test_glitch_pressed();
        logic [3:0] obs, exp;
        test_press();
        for (int j = 0; j < 10; j++) begin
            KEY_IN = (j < 2) ? 1'b0 : 1'b1;
            exp_q.push_back({3'b100, (j == 2) || (j == 3)});
            tick();
            obs = {KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL glitch j=%0d got=%b want=%b", j, obs, exp);
            end
        end
        test_release();
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        for (int j = 0; j < 5; j++) begin
            KEY_IN = 1'b1;
            RST = (j == 4) ? 1'b1 : 1'b0;
            exp_q.push_back((j == 4) ? 4'b0000 : exp_clean(j, 1'b1));
            tick();
            obs = {KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_mid j=%0d got=%b want=%b", j, obs, exp);
            end
        end
        RST = 1'b0;
        for (int j = 0; j < 8; j++) begin
            KEY_IN = 1'b1;
            exp_q.push_back(exp_clean(j, 1'b1));
            tick();
            obs = {KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_requal j=%0d got=%b want=%b", j, obs, exp);
            end
        end
        test_release();
    endtask

`ifdef KEY_DEBOUNCE_TOGGLE_EN
    task automatic test_toggle();
        logic [4:0] obs, exp;
        logic       tog_exp;
        logic [4:0] tq[$];
        tog_exp = 1'b0;
        RST = 1'b1;
        KEY_IN = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        checks++;
        if (TOGGLE_OUT !== 1'b0) begin
            errors++;
            $display("FAIL toggle_reset got=%b want=0", TOGGLE_OUT);
        end
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 8; j++) begin
                KEY_IN = (n % 2 == 0) ? 1'b1 : 1'b0;
                if ((j == 6) && (KEY_IN == 1'b1)) tog_exp = ~tog_exp;
                tq.push_back({tog_exp, exp_clean(j, KEY_IN)});
                tick();
                obs = {TOGGLE_OUT, KEY_OUT, KEY_RISE, KEY_FALL, BUSY};
                exp = tq.pop_front();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL toggle n=%0d j=%0d got=%b want=%b", n, j, obs, exp);
                end
            end
        end
    endtask
`endif

    initial begin
        RST = 1'b1;
        KEY_IN = 1'b0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_glitch_pressed();
        test_reset_mid();
`ifdef KEY_DEBOUNCE_TOGGLE_EN
        test_toggle();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
